mult_control: RTL and testbench
===============================

MULT_CONTROL -- requirements
Module: mult_control

Interface
REQ-001 Parameter: N_BITS, 8, operand width and number of add/shift iterations (legal range 2-16).
REQ-002 Port: Clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: Reset  input  1  reset is asynchronous and active-low (asserted at 0).
REQ-004 Port: Run  input  1  start multiply; level-sensitive, synchronized upstream.
REQ-005 Port: ClearA_LoadB  input  1  request to clear A/X and load B from switches.
REQ-006 Port: M  input  1  current multiplier LSB (B[0]) from datapath.
REQ-007 Port: Clr_Ld  output  1  datapath clear A/X and load B strobe.
REQ-008 Port: Clr_XA  output  1  clear X and A only (B retained) strobe.
REQ-009 Port: Add_En  output  1  A <= A + S (sign-extended into X) this cycle.
REQ-010 Port: Sub_En  output  1  A <= A - S (sign-extended into X) this cycle.
REQ-011 Port: Shift_En  output  1  arithmetic right shift X:A:B this cycle.
REQ-012 Port: Done  output  1  product valid; high while in DONE.

Function
REQ-013 States SHALL be IDLE, CLEAR, ADD, SHIFT, DONE, held in an enum register plus an iteration counter cnt of ceil(log2(N_BITS)) bits.
REQ-014 IDLE: Run=1 -> CLEAR; else stay.
REQ-015 CLEAR: one cycle, Clr_XA=1, cnt<=0; -> ADD.
REQ-016 ADD: one cycle; Add_En = M & (cnt != N_BITS-1); Sub_En = M & (cnt == N_BITS-1); -> SHIFT.
REQ-017 SHIFT: one cycle, Shift_En=1; if cnt == N_BITS-1 -> DONE, else cnt<=cnt+1 and -> ADD.
REQ-018 DONE: Done=1; Run=0 -> IDLE; Run held 1 SHALL NOT retrigger.
REQ-019 IDLE output: Clr_Ld = ClearA_LoadB & ~Run (combinational); Run has priority when both high.
REQ-020 ClearA_LoadB SHALL be ignored in every state other than IDLE.
REQ-021 At most one of Clr_Ld, Clr_XA, Add_En, Sub_En, Shift_En SHALL be high in any cycle; all five low in DONE.
REQ-022 Latency: Run sampled 1 in IDLE at edge 0 -> CLEAR after edge 1, DONE entered after edge 2*N_BITS+2 (18 for N_BITS=8).
REQ-023 Exactly N_BITS Shift_En cycles and exactly N_BITS ADD cycles SHALL occur per operation.
REQ-024 M SHALL be sampled only in ADD, combinationally, in the same cycle the enable is issued.
REQ-025 Run deasserted mid-operation SHALL NOT abort; sequence completes to DONE, then exits to IDLE next edge.
REQ-026 Illegal/unreached state encodings SHALL return to IDLE on the next edge.

Reset
REQ-027 Reset=0 SHALL immediately (without waiting for Clk) force state=IDLE, cnt=0.
REQ-028 While Reset=0 all outputs SHALL be 0, including Clr_Ld regardless of ClearA_LoadB.
REQ-029 Reset asserted mid-operation SHALL abandon the sequence; no enable pulse SHALL follow within the reset cycle.
REQ-030 After Reset returns to 1, the first rising edge SHALL evaluate IDLE transitions normally.

Verification
REQ-031 Reset=0 then 1, Run=0, ClearA_LoadB=1 -> Clr_Ld=1, all other outputs 0, state stays IDLE.
REQ-032 Run=1 held, M=1 every cycle, N_BITS=8 -> Clr_XA once, Add_En 7 pulses, Sub_En 1 pulse (8th ADD), Shift_En 8 pulses, Done=1 at edge 18; Run held -> Done stays 1; Run=0 -> IDLE next edge.
REQ-033 Run=1 with M=0 every cycle -> zero Add_En/Sub_En pulses, 8 Shift_En pulses, Done at edge 18.
REQ-034 Run=1 and ClearA_LoadB=1 same cycle in IDLE -> Clr_Ld=0, CLEAR next edge; ClearA_LoadB=1 during ADD/SHIFT -> Clr_Ld stays 0.
REQ-035 Reset=0 asynchronously midway through SHIFT of iteration 4 -> outputs 0 before next edge, state IDLE, cnt=0; new Run after release -> full 18-edge sequence.
REQ-036 Run pulsed 1 for one cycle then 0 -> full sequence completes, Done high exactly one cycle, then IDLE.

Source files
------------

// File: rtl/mult_control.sv
// mult_control: add/shift multiplier sequencer (clear, N_BITS add+shift iterations, subtract on the final add)
module mult_control #(
  parameter int N_BITS = 8
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Run,
  input  logic ClearA_LoadB,
  input  logic M,
  output logic Clr_Ld,
  output logic Clr_XA,
  output logic Add_En,
  output logic Sub_En,
  output logic Shift_En,
  output logic Done
);
  typedef enum logic [2:0] {IDLE, CLEAR, ADD, SHIFT, DONE} state_t;
  localparam int CW = $clog2(N_BITS);
  localparam logic [CW-1:0] LAST = CW'(N_BITS - 1);
  state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic is_last;
  logic clr_ld, clr_xa, add_en, sub_en, shift_en, done;
  assign is_last = cnt == LAST;
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
    end
  always_comb begin
    state_nxt = IDLE;
    cnt_nxt = cnt;
    clr_ld = 1'b0;
    clr_xa = 1'b0;
    add_en = 1'b0;
    sub_en = 1'b0;
    shift_en = 1'b0;
    done = 1'b0;
    case (state)
      IDLE: begin
        clr_ld = ClearA_LoadB & ~Run;
        state_nxt = Run ? CLEAR : IDLE;
      end
      CLEAR: begin
        clr_xa = 1'b1;
        cnt_nxt = '0;
        state_nxt = ADD;
      end
      ADD: begin
        add_en = M & ~is_last;
        sub_en = M & is_last;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        shift_en = 1'b1;
        cnt_nxt = is_last ? cnt : cnt + 1'b1;
        state_nxt = is_last ? DONE : ADD;
      end
      DONE: begin
        done = 1'b1;
        state_nxt = Run ? DONE : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
  assign Clr_Ld = clr_ld & Reset;
  assign Clr_XA = clr_xa & Reset;
  assign Add_En = add_en & Reset;
  assign Sub_En = sub_en & Reset;
  assign Shift_En = shift_en & Reset;
  assign Done = done & Reset;
endmodule

// File: tb/tb_mult_control.sv
// tb_mult_control: directed self-checking bench for mult_control
module tb_mult_control;
  logic Clk, Reset, Run, ClearA_LoadB, M;
  logic Clr_Ld, Clr_XA, Add_En, Sub_En, Shift_En, Done;
  int n_cmp, n_bad;
  mult_control #(.N_BITS(8)) dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .ClearA_LoadB(ClearA_LoadB), .M(M),
    .Clr_Ld(Clr_Ld), .Clr_XA(Clr_XA), .Add_En(Add_En), .Sub_En(Sub_En),
    .Shift_En(Shift_En), .Done(Done)
  );
  initial begin
    Clk = 0;
    forever #5 Clk = ~Clk;
  end
  function automatic logic [5:0] outs();
    return {Clr_Ld, Clr_XA, Add_En, Sub_En, Shift_En, Done};
  endfunction
  task automatic run_op(input logic m_val, input logic hold,
                        output int ld, output int xa, output int ad, output int sb,
                        output int sh, output int edges, output int viol, output int seen);
    ld = 0; xa = 0; ad = 0; sb = 0; sh = 0; edges = 0; viol = 0; seen = 0;
    Run = 1;
    M = m_val;
    for (int i = 0; i < 60; i++) begin
      @(posedge Clk);
      edges++;
      @(negedge Clk);
      if (!hold) Run = 0;
      ld += int'(Clr_Ld);
      xa += int'(Clr_XA);
      ad += int'(Add_En);
      sb += int'(Sub_En);
      sh += int'(Shift_En);
      if ((int'(Clr_Ld) + int'(Clr_XA) + int'(Add_En) + int'(Sub_En) + int'(Shift_En)) > 1 ||
          (Done && (Clr_Ld | Clr_XA | Add_En | Sub_En | Shift_En)))
        viol++;
      if (Done) begin
        seen = 1;
        break;
      end
    end
  endtask
  task automatic step();
    @(posedge Clk);
    @(negedge Clk);
  endtask
  task automatic test_reset();
    Reset = 1; Run = 0; ClearA_LoadB = 1; M = 0;
    #2 Reset = 0;
    #1;
    n_cmp++;
    if (outs() !== 6'b0) begin n_bad++; $display("FAIL reset_outs got %b want %b", outs(), 6'b0); end
    n_cmp++;
    if (dut.state !== 3'd0 || dut.cnt !== 3'd0) begin n_bad++; $display("FAIL reset_state got %0d/%0d want 0/0", dut.state, dut.cnt); end
    @(negedge Clk);
    Reset = 1;
    #1;
    n_cmp++;
    if (outs() !== 6'b100000) begin n_bad++; $display("FAIL idle_clr_ld got %b want %b", outs(), 6'b100000); end
    @(negedge Clk);
    step();
    n_cmp++;
    if (dut.state !== 3'd0 || outs() !== 6'b100000) begin n_bad++; $display("FAIL idle_stay got state %0d outs %b want 0 100000", dut.state, outs()); end
    ClearA_LoadB = 0;
    #1;
    n_cmp++;
    if (outs() !== 6'b0) begin n_bad++; $display("FAIL idle_quiet got %b want %b", outs(), 6'b0); end
  endtask
  task automatic test_m_one();
    int ld, xa, ad, sb, sh, edges, viol, seen;
    run_op(1'b1, 1'b1, ld, xa, ad, sb, sh, edges, viol, seen);
    n_cmp++;
    if (seen !== 1 || edges !== 18) begin n_bad++; $display("FAIL m1_latency got seen %0d edges %0d want 1 18", seen, edges); end
    n_cmp++;
    if (xa !== 1 || ad !== 7 || sb !== 1 || sh !== 8) begin n_bad++; $display("FAIL m1_pulses got xa %0d add %0d sub %0d sh %0d want 1 7 1 8", xa, ad, sb, sh); end
    n_cmp++;
    if (viol !== 0) begin n_bad++; $display("FAIL m1_onehot got %0d violations want 0", viol); end
    step();
    step();
    n_cmp++;
    if (outs() !== 6'b000001) begin n_bad++; $display("FAIL m1_done_hold got %b want %b", outs(), 6'b000001); end
    Run = 0;
    step();
    n_cmp++;
    if (dut.state !== 3'd0 || Done !== 1'b0) begin n_bad++; $display("FAIL m1_exit got state %0d done %b want 0 0", dut.state, Done); end
  endtask
  task automatic test_m_zero();
    int ld, xa, ad, sb, sh, edges, viol, seen;
    run_op(1'b0, 1'b1, ld, xa, ad, sb, sh, edges, viol, seen);
    n_cmp++;
    if (seen !== 1 || edges !== 18) begin n_bad++; $display("FAIL m0_latency got seen %0d edges %0d want 1 18", seen, edges); end
    n_cmp++;
    if (ad !== 0 || sb !== 0 || sh !== 8 || xa !== 1) begin n_bad++; $display("FAIL m0_pulses got add %0d sub %0d sh %0d xa %0d want 0 0 8 1", ad, sb, sh, xa); end
    Run = 0;
    step();
  endtask
  task automatic test_priority();
    int ld, xa, ad, sb, sh, edges, viol, seen;
    ClearA_LoadB = 1;
    Run = 1;
    #1;
    n_cmp++;
    if (Clr_Ld !== 1'b0) begin n_bad++; $display("FAIL prio_clr_ld got %b want 0", Clr_Ld); end
    run_op(1'b1, 1'b1, ld, xa, ad, sb, sh, edges, viol, seen);
    n_cmp++;
    if (ld !== 0 || edges !== 18 || xa !== 1) begin n_bad++; $display("FAIL prio_busy got ld %0d edges %0d xa %0d want 0 18 1", ld, edges, xa); end
    Run = 0;
    step();
    n_cmp++;
    if (outs() !== 6'b100000) begin n_bad++; $display("FAIL prio_back_idle got %b want %b", outs(), 6'b100000); end
    ClearA_LoadB = 0;
  endtask
  task automatic test_async_reset();
    int ld, xa, ad, sb, sh, edges, viol, seen;
    Run = 1;
    M = 1;
    for (int i = 0; i < 9; i++) step();
    n_cmp++;
    if (outs() !== 6'b000010 || dut.cnt !== 3'd3) begin n_bad++; $display("FAIL ar_pre got %b cnt %0d want 000010 3", outs(), dut.cnt); end
    ClearA_LoadB = 1;
    #2 Reset = 0;
    #1;
    n_cmp++;
    if (outs() !== 6'b0 || dut.state !== 3'd0 || dut.cnt !== 3'd0) begin n_bad++; $display("FAIL ar_immediate got %b state %0d cnt %0d want 0 0 0", outs(), dut.state, dut.cnt); end
    step();
    n_cmp++;
    if (outs() !== 6'b0) begin n_bad++; $display("FAIL ar_held got %b want %b", outs(), 6'b0); end
    Run = 0;
    ClearA_LoadB = 0;
    Reset = 1;
    step();
    n_cmp++;
    if (dut.state !== 3'd0 || outs() !== 6'b0) begin n_bad++; $display("FAIL ar_release got state %0d outs %b want 0 0", dut.state, outs()); end
    run_op(1'b1, 1'b1, ld, xa, ad, sb, sh, edges, viol, seen);
    n_cmp++;
    if (seen !== 1 || edges !== 18 || ad !== 7 || sb !== 1 || sh !== 8) begin n_bad++; $display("FAIL ar_rerun got edges %0d add %0d sub %0d sh %0d want 18 7 1 8", edges, ad, sb, sh); end
    Run = 0;
    step();
  endtask
  task automatic test_run_pulse();
    int ld, xa, ad, sb, sh, edges, viol, seen;
    run_op(1'b1, 1'b0, ld, xa, ad, sb, sh, edges, viol, seen);
    n_cmp++;
    if (seen !== 1 || edges !== 18 || sh !== 8) begin n_bad++; $display("FAIL pulse_complete got seen %0d edges %0d sh %0d want 1 18 8", seen, edges, sh); end
    n_cmp++;
    if (viol !== 0) begin n_bad++; $display("FAIL pulse_onehot got %0d violations want 0", viol); end
    step();
    n_cmp++;
    if (Done !== 1'b0 || dut.state !== 3'd0) begin n_bad++; $display("FAIL pulse_done_once got done %b state %0d want 0 0", Done, dut.state); end
  endtask
  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_m_one();
    test_m_zero();
    test_priority();
    test_async_reset();
    test_run_pulse();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
